// File: rtl/freq_meas_pkg.sv
// rtl/freq_meas_pkg.sv - shared state type, widths and saturating increment for freq_meas_sched
package freq_meas_pkg;

  localparam int CNT_W  = 16;
  localparam int CHAN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_REPORT
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/freq_gate_counter.sv
// rtl/freq_gate_counter.sv - edge detector plus saturating edge and high-time counters
// Outputs are the next-state counts so the caller can capture the final gate cycle on exit.
module freq_gate_counter
  import freq_meas_pkg::*;
(
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             count_en_i,
  input  logic             sample_i,
  output logic [CNT_W-1:0] freq_d_o,
  output logic [CNT_W-1:0] high_d_o
);

  logic             prev_q;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic [CNT_W-1:0] high_q, high_d;

  always_comb begin
    freq_d = freq_q;
    high_d = high_q;
    if (clear_i) begin
      freq_d = '0;
      high_d = '0;
    end else if (count_en_i) begin
      if (sample_i && !prev_q) freq_d = sat_inc(freq_q);
      if (sample_i)            high_d = sat_inc(high_q);
    end
  end

  // History tracks the sample every cycle, so the settle window primes it for the gate.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      freq_q <= '0;
      high_q <= '0;
    end else begin
      prev_q <= sample_i;
      freq_q <= freq_d;
      high_q <= high_d;
    end
  end

  assign freq_d_o = freq_d;
  assign high_d_o = high_d;

endmodule

// File: rtl/freq_meas_sched.sv
// rtl/freq_meas_sched.sv - round-robin gated frequency/high-time measurement scheduler
// Define FREQ_MEAS_SYNC_EN to insert a two-flop synchronizer on every in_signal bit.
module freq_meas_sched
  import freq_meas_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int GATE_CYC   = 65535,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [NCH-1:0]    in_signal,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CHAN_W-1:0] res_chan,
  output logic [CNT_W-1:0]  res_freq,
  output logic [CNT_W-1:0]  res_high,
  output logic              busy
);

  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic              started_q, started_d;
  logic              res_valid_q, res_valid_d;
  logic [CHAN_W-1:0] res_chan_q, res_chan_d;
  logic [CNT_W-1:0]  res_freq_q, res_freq_d;
  logic [CNT_W-1:0]  res_high_q, res_high_d;

  logic [NCH-1:0]    samp_q;
  logic              sel_sample;
  logic [CHAN_W-1:0] next_chan, lo_chan, hi_chan;
  logic              hi_found;
  logic              mask_any;
  logic [CNT_W-1:0]  freq_nxt, high_nxt;

`ifdef FREQ_MEAS_SYNC_EN
  logic [NCH-1:0] sync0_q, sync1_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= '0;
      sync1_q <= '0;
      samp_q  <= '0;
    end else begin
      sync0_q <= in_signal;
      sync1_q <= sync0_q;
      samp_q  <= sync1_q;
    end
  end
`else
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) samp_q <= '0;
    else        samp_q <= in_signal;
  end
`endif

  always_comb begin
    sel_sample = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (chan_q == CHAN_W'(i)) sel_sample = samp_q[i];
    end
  end

  // Lowest set bit overall, and lowest set bit above the current channel (wrap falls back to lowest).
  always_comb begin
    lo_chan  = '0;
    hi_chan  = '0;
    hi_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (chan_mask[i]) begin
        lo_chan = CHAN_W'(i);
        if (CHAN_W'(i) > chan_q) begin
          hi_chan  = CHAN_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    next_chan = (started_q && hi_found) ? hi_chan : lo_chan;
  end

  assign mask_any = |chan_mask;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    chan_d      = chan_q;
    started_d   = started_q;
    res_valid_d = res_valid_q;
    res_chan_d  = res_chan_q;
    res_freq_d  = res_freq_q;
    res_high_d  = res_high_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && mask_any) begin
          state_d   = ST_SETTLE;
          cyc_d     = '0;
          chan_d    = next_chan;
          started_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cyc_q == SETTLE_LAST) begin
          state_d = ST_GATE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      ST_GATE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cyc_q == GATE_LAST) begin
          state_d     = ST_REPORT;
          res_valid_d = 1'b1;
          res_chan_d  = chan_q;
          res_freq_d  = freq_nxt;
          res_high_d  = high_nxt;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      ST_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (enable && mask_any) begin
            state_d = ST_SETTLE;
            cyc_d   = '0;
            chan_d  = next_chan;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      chan_q      <= '0;
      started_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_chan_q  <= '0;
      res_freq_q  <= '0;
      res_high_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      chan_q      <= chan_d;
      started_q   <= started_d;
      res_valid_q <= res_valid_d;
      res_chan_q  <= res_chan_d;
      res_freq_q  <= res_freq_d;
      res_high_q  <= res_high_d;
    end
  end

  freq_gate_counter u_cnt (
    .clock      (clock),
    .rst_n      (rst_n),
    .clear_i    (state_q != ST_GATE),
    .count_en_i (state_q == ST_GATE),
    .sample_i   (sel_sample),
    .freq_d_o   (freq_nxt),
    .high_d_o   (high_nxt)
  );

  assign res_valid = res_valid_q;
  assign res_chan  = res_chan_q;
  assign res_freq  = res_freq_q;
  assign res_high  = res_high_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_freq_meas_sched.sv
// tb/tb_freq_meas_sched.sv - randomized self-checking bench for freq_meas_sched
module tb_freq_meas_sched;

  localparam int NCH    = 4;
  localparam int GATE   = 1000;
  localparam int SETTLE = 4;
  localparam int DEPTH  = 131072;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n = 1'b0, enable = 1'b0, res_ready = 1'b0;
  logic [3:0]  chan_mask = 4'b0, in_signal = 4'b0;
  logic        res_valid, busy;
  logic [3:0]  res_chan;
  logic [15:0] res_freq, res_high;

  logic        rst_n_b = 1'b0, enable_b = 1'b0, res_ready_b = 1'b0;
  logic [3:0]  chan_mask_b = 4'b0, in_signal_b = 4'b0;
  logic        res_valid_b, busy_b;
  logic [3:0]  res_chan_b;
  logic [15:0] res_freq_b, res_high_b;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic [3:0] in_hist [0:DEPTH-1];
  int per [4] = '{0, 0, 0, 0};
  int hi  [4] = '{0, 0, 0, 0};
  int ph  [4] = '{0, 0, 0, 0};
  bit rdy_rand = 1'b0;
  int exp_next = 0;
  bit hs_pend = 1'b0;
  int hs_chan = 0;

  freq_meas_sched #(.NCH(NCH), .GATE_CYC(GATE), .SETTLE_CYC(SETTLE)) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .chan_mask(chan_mask),
    .in_signal(in_signal), .res_valid(res_valid), .res_ready(res_ready),
    .res_chan(res_chan), .res_freq(res_freq), .res_high(res_high), .busy(busy)
  );

  freq_meas_sched #(.NCH(NCH), .GATE_CYC(65535), .SETTLE_CYC(SETTLE)) dut_b (
    .clock(clock), .rst_n(rst_n_b), .enable(enable_b), .chan_mask(chan_mask_b),
    .in_signal(in_signal_b), .res_valid(res_valid_b), .res_ready(res_ready_b),
    .res_chan(res_chan_b), .res_freq(res_freq_b), .res_high(res_high_b), .busy(busy_b)
  );

  function automatic int next_after(input logic [3:0] mask, input int cur);
    for (int d = 1; d <= NCH; d++) begin
      if (mask[(cur + d) % NCH]) return (cur + d) % NCH;
    end
    return cur;
  endfunction

  function automatic int lowest(input logic [3:0] mask);
    for (int c = 0; c < NCH; c++) if (mask[c]) return c;
    return 0;
  endfunction

  // Result ending at edge e covers the GATE samples captured at edges e-GATE .. e-1.
  function automatic void model(input int e, input int ch, output int f, output int h);
    f = 0;
    h = 0;
    for (int j = e - GATE; j < e; j++) begin
      if (in_hist[j][ch] === 1'b1) begin
        if (h < 65535) h++;
        if (in_hist[j-1][ch] !== 1'b1 && f < 65535) f++;
      end
    end
  endfunction

  initial forever begin
    @(posedge clock);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (per[c] > 1) begin
        in_signal[c] = (ph[c] < hi[c]);
        ph[c] = (ph[c] + 1) % per[c];
      end else begin
        in_signal[c] = 1'b0;
      end
    end
    if (rdy_rand) res_ready = 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(posedge clock);
    cyc++;
    if (hs_pend) exp_next = hs_chan;
    @(negedge clock);
    if (cyc + 1 < DEPTH) in_hist[cyc+1] = in_signal;
    hs_pend = (rst_n && res_valid && res_ready && enable && chan_mask != 4'b0);
    if (hs_pend) hs_chan = next_after(chan_mask, int'(res_chan));
  end

  task automatic random_waves();
    for (int c = 0; c < NCH; c++) begin
      per[c] = int'($urandom_range(2, 40));
      hi[c]  = int'($urandom_range(1, per[c] - 1));
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    rst_n = 1'b0; enable = 1'b0; res_ready = 1'b0; rdy_rand = 1'b0;
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_result(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (res_valid) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", res_valid); end
    n_cmp++; if (res_chan !== 4'd0) begin n_bad++; $display("FAIL reset_chan got %0d want 0", res_chan); end
    n_cmp++; if (res_freq !== 16'd0) begin n_bad++; $display("FAIL reset_freq got %0d want 0", res_freq); end
    n_cmp++; if (res_high !== 16'd0) begin n_bad++; $display("FAIL reset_high got %0d want 0", res_high); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_square();
    bit to; int f, h;
    do_reset();
    per[0] = 10; hi[0] = 5;
    chan_mask = 4'b0001; res_ready = 1'b1; enable = 1'b1;
    for (int r = 0; r < 2; r++) begin
      wait_result(3000, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL square_timeout got none want result %0d", r); end
      else begin
        model(cyc, 0, f, h);
        n_cmp++; if (res_chan !== 4'd0) begin n_bad++; $display("FAIL square_chan got %0d want 0", res_chan); end
        n_cmp++; if (res_freq !== 16'd100) begin n_bad++; $display("FAIL square_freq got %0d want 100", res_freq); end
        n_cmp++; if (res_high !== 16'd500) begin n_bad++; $display("FAIL square_high got %0d want 500", res_high); end
        n_cmp++; if (res_freq !== 16'(f) || res_high !== 16'(h)) begin
          n_bad++; $display("FAIL square_model got %0d/%0d want %0d/%0d", res_freq, res_high, f, h); end
      end
    end
    @(posedge clock); #1 enable = 1'b0;
  endtask

  task automatic test_round_robin();
    bit to; int f, h;
    int order [4] = '{1, 3, 1, 3};
    do_reset();
    random_waves();
    chan_mask = 4'b1010; res_ready = 1'b1; enable = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_result(3000, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL rr_timeout got none want result %0d", r); end
      else begin
        model(cyc, order[r], f, h);
        n_cmp++; if (res_chan !== 4'(order[r])) begin n_bad++; $display("FAIL rr_chan got %0d want %0d", res_chan, order[r]); end
        n_cmp++; if (res_freq !== 16'(f) || res_high !== 16'(h)) begin
          n_bad++; $display("FAIL rr_counts got %0d/%0d want %0d/%0d", res_freq, res_high, f, h); end
      end
    end
    @(posedge clock); #1 enable = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to; int f, h, hs;
    logic [3:0] c0; logic [15:0] f0, h0;
    do_reset();
    random_waves();
    chan_mask = 4'b0100; res_ready = 1'b0; enable = 1'b1;
    wait_result(3000, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL bp_timeout got none want first result"); end
    else begin
      model(cyc, 2, f, h);
      c0 = res_chan; f0 = res_freq; h0 = res_high;
      n_cmp++; if (c0 !== 4'd2 || f0 !== 16'(f) || h0 !== 16'(h)) begin
        n_bad++; $display("FAIL bp_data got %0d:%0d/%0d want 2:%0d/%0d", c0, f0, h0, f, h); end
      for (int i = 0; i < 50; i++) begin
        @(negedge clock);
        n_cmp++;
        if (res_valid !== 1'b1 || res_chan !== c0 || res_freq !== f0 || res_high !== h0 || busy !== 1'b1) begin
          n_bad++; $display("FAIL bp_hold cycle %0d got v=%b %0d:%0d/%0d want v=1 %0d:%0d/%0d",
                            i, res_valid, res_chan, res_freq, res_high, c0, f0, h0); end
      end
      @(posedge clock); #1 res_ready = 1'b1;
      hs = cyc + 1;
      @(negedge clock);
      @(negedge clock);
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drop got %b want 0", res_valid); end
      wait_result(3000, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL bp_timeout2 got none want second result"); end
      else begin
        model(cyc, 2, f, h);
        n_cmp++; if (cyc !== hs + SETTLE + GATE) begin
          n_bad++; $display("FAIL bp_restart got edge %0d want %0d", cyc, hs + SETTLE + GATE); end
        n_cmp++; if (res_chan !== 4'd2 || res_freq !== 16'(f) || res_high !== 16'(h)) begin
          n_bad++; $display("FAIL bp_data2 got %0d:%0d/%0d want 2:%0d/%0d", res_chan, res_freq, res_high, f, h); end
      end
    end
    @(posedge clock); #1 enable = 1'b0;
  endtask

  task automatic test_random();
    bit to; int f, h, ec;
    logic [3:0] c0; logic [15:0] f0, h0;
    do_reset();
    random_waves();
    chan_mask = 4'($urandom_range(1, 15));
    exp_next = lowest(chan_mask);
    rdy_rand = 1'b1; enable = 1'b1;
    for (int r = 0; r < 5; r++) begin
      wait_result(3000, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL rnd_timeout got none want result %0d", r); break; end
      ec = exp_next;
      model(cyc, ec, f, h);
      c0 = res_chan; f0 = res_freq; h0 = res_high;
      n_cmp++; if (c0 !== 4'(ec) || f0 !== 16'(f) || h0 !== 16'(h)) begin
        n_bad++; $display("FAIL rnd_data got %0d:%0d/%0d want %0d:%0d/%0d", c0, f0, h0, ec, f, h); end
      for (int i = 0; i < 300 && res_valid; i++) begin
        @(negedge clock);
        if (res_valid) begin
          n_cmp++; if (res_chan !== c0 || res_freq !== f0 || res_high !== h0) begin
            n_bad++; $display("FAIL rnd_hold got %0d:%0d/%0d want %0d:%0d/%0d", res_chan, res_freq, res_high, c0, f0, h0); end
        end
      end
      // Mid-gate mask change must not disturb the channel already being measured.
      repeat (300) @(posedge clock);
      #1 chan_mask = 4'($urandom_range(1, 15));
    end
    @(posedge clock); #1;
    rdy_rand = 1'b0; res_ready = 1'b1; enable = 1'b0;
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    do_reset();
    random_waves();
    chan_mask = 4'b0001; res_ready = 1'b1; enable = 1'b1;
    repeat (SETTLE + 300) @(posedge clock);
    #1 enable = 1'b0;
    @(negedge clock);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got %b want 1", busy); end
    @(negedge clock);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle got %b want 0", busy); end
    for (int i = 0; i < 1100; i++) begin
      @(negedge clock);
      if (res_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_valid got 1 want 0"); end
  endtask

  task automatic test_reset_report();
    bit to;
    do_reset();
    random_waves();
    chan_mask = 4'b1111; res_ready = 1'b1; enable = 1'b1;
    wait_result(3000, to);
    @(posedge clock); #1 res_ready = 1'b0;
    wait_result(3000, to);
    n_cmp++; if (to || res_chan !== 4'd1) begin
      n_bad++; $display("FAIL rr_pre_reset got to=%b chan %0d want to=0 chan 1", to, res_chan); end
    repeat (5) @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_report_flags got v=%b busy=%b want 0/0", res_valid, busy); end
    n_cmp++; if (res_chan !== 4'd0 || res_freq !== 16'd0 || res_high !== 16'd0) begin
      n_bad++; $display("FAIL rst_report_data got %0d:%0d/%0d want 0:0/0", res_chan, res_freq, res_high); end
    @(posedge clock); #1;
    rst_n = 1'b1; res_ready = 1'b1; enable = 1'b1;
    wait_result(3000, to);
    n_cmp++; if (to || res_chan !== 4'd0) begin
      n_bad++; $display("FAIL rst_first_chan got to=%b chan %0d want to=0 chan 0", to, res_chan); end
    @(posedge clock); #1 enable = 1'b0;
  endtask

  task automatic test_saturation();
    bit to = 1'b1;
    in_signal_b = 4'b0001; chan_mask_b = 4'b0001; res_ready_b = 1'b1;
    repeat (3) @(posedge clock);
    #1 rst_n_b = 1'b1;
    @(posedge clock); #1 enable_b = 1'b1;
    for (int i = 0; i < 66000; i++) begin
      @(negedge clock);
      if (res_valid_b) begin to = 1'b0; break; end
    end
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL sat_timeout got none want result"); end
    else begin
      n_cmp++; if (res_high_b !== 16'hFFFF) begin n_bad++; $display("FAIL sat_high got %0d want 65535", res_high_b); end
      n_cmp++; if (res_freq_b !== 16'd0) begin n_bad++; $display("FAIL sat_freq got %0d want 0", res_freq_b); end
      n_cmp++; if (res_chan_b !== 4'd0) begin n_bad++; $display("FAIL sat_chan got %0d want 0", res_chan_b); end
    end
    @(posedge clock); #1 enable_b = 1'b0;
  endtask

  initial begin
    fork
      test_saturation();
      begin
        test_reset();
        test_square();
        test_round_robin();
        test_backpressure();
        test_random();
        test_abort();
        test_reset_report();
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_meas_sched.md
FREQ_MEAS_SCHED -- requirements
Module: freq_meas_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of measured input channels (2..16).
REQ-002 SHALL have parameter GATE_CYC, default 65535, gate window length in clock cycles (1..65535).
REQ-003 SHALL have parameter SETTLE_CYC, default 4, discard cycles after each channel switch (1..255).
REQ-004 SHALL have port clock, input, 1, sole clock of the block.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port enable, input, 1, run round-robin measurement while high.
REQ-007 SHALL have port chan_mask, input, NCH, channels eligible for measurement.
REQ-008 SHALL have port in_signal, input, NCH, asynchronous signals to be measured.
REQ-009 SHALL have port res_valid, output, 1, result available.
REQ-010 SHALL have port res_ready, input, 1, result consumed by the sink.
REQ-011 SHALL have port res_chan, output, 4, channel index of the result.
REQ-012 SHALL have port res_freq, output, 16, rising edges counted in the gate window.
REQ-013 SHALL have port res_high, output, 16, clock cycles the signal was high in the gate window.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, SETTLE, GATE and REPORT.
REQ-016 IDLE SHALL go to SETTLE when enable=1 and chan_mask!=0, selecting the lowest set mask bit on the first start and the next set bit after the last channel (wrapping) thereafter.
REQ-017 SETTLE SHALL last exactly SETTLE_CYC cycles, load the edge-detect history from the selected channel, and count nothing.
REQ-018 GATE SHALL last exactly GATE_CYC cycles, incrementing the edge count on each sampled 0->1 and the high count on each sampled 1.
REQ-019 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-020 On GATE exit the block SHALL register res_chan, res_freq and res_high, assert res_valid in the next cycle, and enter REPORT.
REQ-021 In REPORT, outputs SHALL hold stable until res_valid and res_ready are both high in the same cycle.
REQ-022 After that handshake, REPORT SHALL go to SETTLE on the next eligible channel if enable=1 and chan_mask!=0, otherwise to IDLE.
REQ-023 enable=0 during SETTLE or GATE SHALL abort to IDLE on the next cycle and discard partial counts.
REQ-024 A chan_mask change SHALL take effect only at the next channel selection.
REQ-025 If the current channel is the only set mask bit, the same channel SHALL be re-measured.
REQ-026 res_ready SHALL be ignored while res_valid=0.
REQ-027 A 0->1 transition that straddles the SETTLE->GATE boundary SHALL count as an edge in GATE.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, res_valid=0, res_chan=0, res_freq=0, res_high=0, busy=0, clear all counters and synchronizers, and reset round-robin to channel 0.
REQ-029 Reset mid-GATE or mid-REPORT SHALL drop any pending result.

Configuration
REQ-030 With FREQ_MEAS_SYNC_EN defined, each in_signal bit SHALL pass through a two-flop synchronizer before selection, adding 2 cycles of sampling delay.
REQ-031 Without FREQ_MEAS_SYNC_EN, in_signal SHALL be sampled directly by one register, and the inputs SHALL be required to be synchronous to clock.

Structure
REQ-032 Package freq_meas_pkg SHALL hold the state enum typedef, CNT_W=16, CHAN_W=4, and a saturating-increment function.
REQ-033 Sub-module freq_gate_counter SHALL contain the edge detector and the two saturating counters, with clear, count_en, sample input and count outputs.
REQ-034 freq_meas_sched SHALL contain the FSM, round-robin select, input mux and result registers.

Verification
REQ-035 With NCH=4, GATE_CYC=1000 and SETTLE_CYC=4, a square wave of period 10 on ch0, mask=4'b0001 and res_ready=1 SHALL give res_freq=100, res_high=500, res_chan=0.
REQ-036 With mask=4'b1010 and enable=1, results SHALL be reported in channel order 1,3,1,3.
REQ-037 With res_ready=0 for 50 cycles during REPORT, res_valid and the data SHALL stay stable, and GATE SHALL not restart until the handshake.
REQ-038 With GATE_CYC=65535 and ch0 held high, the high count SHALL be res_high=65535 with no wrap and res_freq=0.
REQ-039 Dropping enable at GATE cycle 300 SHALL return the block to IDLE on the next cycle with res_valid never asserted.
REQ-040 Asserting rst_n=0 during REPORT SHALL clear all outputs immediately, and after release with enable=1 the first channel measured SHALL be channel 0.
